zuss_dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of ZUSS_DATA_MEM. It shares the single data memory between the core load/store port (port 0) and a DMA/debug port (port 1) using round-robin arbitration. It converts byte/half/word requests into byte-lane write enables and lane-replicated write data, and extracts and sign- or zero-extends load data. Misaligned and illegal-size requests are rejected without touching memory.

---
 rtl/zuss_dmem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_zuss_dmem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zuss_dmem_arbiter.sv
// Round-robin two-port arbiter and byte/half/word access sequencer in front of
// a single data memory with one-cycle read latency. Every access runs IDLE->ISSUE->WAIT->RESP.
module zuss_dmem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [1:0]        r0_size,
  input  logic              r0_signed,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [31:0]       r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [31:0]       r0_rdata,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [1:0]        r1_size,
  input  logic              r1_signed,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [31:0]       r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [31:0]       r1_rdata,
  output logic              r1_err,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  input  logic [31:0]       mem_out,
  output logic [1:0]        dbg_state
);

  // Handshake: a port raises rN_req with all rN_* fields stable and holds them until
  // rN_gnt, a one-cycle combinational pulse in IDLE; fields are captured on that edge.
  // rN_rvalid is a one-cycle pulse three cycles later carrying rN_rdata/rN_err.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state;
  logic              last;
  logic              port_q;
  logic              we_q;
  logic              sgn_q;
  logic              err_q;
  logic [1:0]        size_q;
  logic [1:0]        lo_q;

  logic              any_req;
  logic              sel;
  logic              sel_we;
  logic              sel_signed;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_bad;
  logic [31:0]       shifted;
  logic [31:0]       load_val;

  function automatic logic is_bad(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_we(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // When both ports request, the one that did not win last time goes first.
  always_comb begin
    any_req    = r0_req | r1_req;
    sel        = (r0_req && r1_req) ? ~last : r1_req;
    r0_gnt     = !rst && (state == IDLE) && any_req && !sel;
    r1_gnt     = !rst && (state == IDLE) && any_req && sel;
    sel_we     = sel ? r1_we     : r0_we;
    sel_size   = sel ? r1_size   : r0_size;
    sel_signed = sel ? r1_signed : r0_signed;
    sel_addr   = sel ? r1_addr   : r0_addr;
    sel_wdata  = sel ? r1_wdata  : r0_wdata;
    sel_bad    = is_bad(sel_size, sel_addr[1:0]);
  end

  // Legal halves have lo[0] = 0, so shifting by 8*lo equals shifting by 16*lo[1].
  always_comb begin
    shifted = mem_out >> {lo_q, 3'b000};
    case (size_q)
      2'b00:   load_val = sgn_q ? {{24{shifted[7]}}, shifted[7:0]} : {24'd0, shifted[7:0]};
      2'b01:   load_val = sgn_q ? {{16{shifted[15]}}, shifted[15:0]} : {16'd0, shifted[15:0]};
      default: load_val = mem_out;
    endcase
    if (err_q || we_q) load_val = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      port_q    <= 1'b0;
      we_q      <= 1'b0;
      sgn_q     <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= 2'b00;
      lo_q      <= 2'b00;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_data  <= '0;
      r0_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r0_err    <= 1'b0;
      r1_rvalid <= 1'b0;
      r1_rdata  <= '0;
      r1_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            port_q   <= sel;
            last     <= sel;
            we_q     <= sel_we;
            size_q   <= sel_size;
            sgn_q    <= sel_signed;
            lo_q     <= sel_addr[1:0];
            err_q    <= sel_bad;
            mem_addr <= {sel_addr[ADDR_W-1:2], 2'b00};
            if (sel_we && !sel_bad) begin
              mem_we   <= lane_we(sel_size, sel_addr[1:0]);
              mem_data <= lane_data(sel_size, sel_wdata);
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          mem_we   <= '0;
          mem_data <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          mem_addr <= '0;
          if (port_q) begin
            r1_rvalid <= 1'b1;
            r1_rdata  <= load_val;
            r1_err    <= err_q;
          end else begin
            r0_rvalid <= 1'b1;
            r0_rdata  <= load_val;
            r0_err    <= err_q;
          end
          state <= RESP;
        end
        RESP: begin
          r0_rvalid <= 1'b0;
          r0_rdata  <= '0;
          r0_err    <= 1'b0;
          r1_rvalid <= 1'b0;
          r1_rdata  <= '0;
          r1_err    <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_zuss_dmem_arbiter.sv
// Bench for zuss_dmem_arbiter: byte-addressed reference memory and transaction-level
// arbitration model feed an expected queue that a separate response monitor drains.
module tb_zuss_dmem_arbiter;

  localparam int W = 50;  // {port, due_cycle[15:0], err, rdata[31:0]}

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [1:0]  sgn;
  logic [1:0]  size [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [1:0]  err;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [31:0] mem_out;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  zuss_dmem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .r0_req(req[0]), .r0_we(we[0]), .r0_size(size[0]), .r0_signed(sgn[0]),
    .r0_addr(addr[0]), .r0_wdata(wdata[0]), .r0_gnt(gnt[0]), .r0_rvalid(rvalid[0]),
    .r0_rdata(rdata0), .r0_err(err[0]),
    .r1_req(req[1]), .r1_we(we[1]), .r1_size(size[1]), .r1_signed(sgn[1]),
    .r1_addr(addr[1]), .r1_wdata(wdata[1]), .r1_gnt(gnt[1]), .r1_rvalid(rvalid[1]),
    .r1_rdata(rdata1), .r1_err(err[1]),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_out(mem_out),
    .dbg_state(dbg_state)
  );

  // Stand-in data memory: registered read of the old word, byte-lane writes.
  logic [31:0] dmem [0:1023];
  always @(posedge clk) begin
    mem_out <= dmem[mem_addr[11:2]];
    for (int k = 0; k < 4; k++)
      if (mem_we[k]) dmem[mem_addr[11:2]][8*k +: 8] = mem_data[8*k +: 8];
  end

  // ---------------- reference model ----------------
  logic [7:0]   ref_b [0:4095];
  logic [W-1:0] exp_q [$];

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic bad_req(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] s, input logic sg, input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = nbytes(s);
    v = '0;
    for (int j = 0; j < n; j++) v = v | (32'(ref_b[int'(a[11:0]) + j]) << (8 * j));
    if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  int          since;
  int          cyc;
  logic        m_last;
  logic        pend;
  logic [1:0]  pend_s;
  logic [31:0] pend_a;
  logic [31:0] pend_d;
  logic [3:0]  x_mask;
  logic [31:0] x_maddr;
  logic [31:0] x_data;
  logic [31:0] x_dmask;

  // Arbitration, bus-timing and reference-memory model, one step per cycle.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_gnt", {30'd0, gnt}, 32'd0);
      chk("rst_rvalid", {30'd0, rvalid}, 32'd0);
      chk("rst_err", {30'd0, err}, 32'd0);
      chk("rst_rdata0", rdata0, 32'd0);
      chk("rst_rdata1", rdata1, 32'd0);
      chk("rst_mem_we", {28'd0, mem_we}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_data", mem_data, 32'd0);
      m_last = 1'b1;
      since  = 4;
      cyc    = 0;
      pend   = 1'b0;
      exp_q.delete();
    end else begin
      logic [1:0]  xg;
      logic [1:0]  s;
      logic [31:0] a;
      logic [31:0] r;
      logic        bd;
      int          w;
      int          lane;
      cyc++;
      if (since < 4) since++;
      case (since)
        1: begin
          chk("issue_mem_we", {28'd0, mem_we}, {28'd0, x_mask});
          chk("issue_mem_addr", mem_addr, x_maddr);
          chk("issue_mem_data", mem_data & x_dmask, x_data);
        end
        2: begin
          chk("wait_mem_we", {28'd0, mem_we}, 32'd0);
          chk("wait_mem_addr", mem_addr, x_maddr);
          if (pend) begin
            for (int j = 0; j < nbytes(pend_s); j++)
              ref_b[int'(pend_a[11:0]) + j] = pend_d[8*j +: 8];
            pend = 1'b0;
          end
        end
        default: begin
          chk("idle_mem_we", {28'd0, mem_we}, 32'd0);
          chk("idle_mem_addr", mem_addr, 32'd0);
          chk("idle_mem_data", mem_data, 32'd0);
        end
      endcase
      xg = 2'b00;
      if (since == 4 && req != 2'b00) begin
        w = (req == 2'b11) ? (m_last ? 0 : 1) : (req[1] ? 1 : 0);
        xg[w]  = 1'b1;
        m_last = w[0];
        since  = 0;
        s  = size[w];
        a  = addr[w];
        bd = bad_req(s, a);
        x_maddr = {a[31:2], 2'b00};
        x_mask  = '0;
        x_data  = '0;
        x_dmask = '0;
        if (we[w] && !bd) begin
          for (int j = 0; j < nbytes(s); j++) begin
            lane = int'(a[1:0]) + j;
            x_mask[lane]          = 1'b1;
            x_data[8*lane +: 8]   = wdata[w][8*j +: 8];
            x_dmask[8*lane +: 8]  = 8'hFF;
          end
        end
        pend   = we[w] && !bd;
        pend_s = s;
        pend_a = a;
        pend_d = wdata[w];
        r = (bd || we[w]) ? 32'd0 : ref_load(s, sgn[w], a);
        exp_q.push_back({w[0], 16'(cyc + 3), bd, r});
      end
      chk("gnt", {30'd0, gnt}, {30'd0, xg});
    end
  end

  // ---------------- response monitor ----------------
  int mcyc;
  always @(negedge clk) begin
    if (rst) begin
      mcyc = 0;
    end else begin
      logic [W-1:0] e;
      mcyc++;
      while (exp_q.size() > 0 && int'(exp_q[0][48:33]) < mcyc) begin
        e = exp_q.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL rvalid_missing: port %0d got no response, expected at cycle %0d", e[49], e[48:33]);
      end
      if (rvalid != 2'b00) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rvalid_unexpected: got rvalid %b expected none at %0t", rvalid, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rvalid_port", {30'd0, rvalid}, e[49] ? 32'd2 : 32'd1);
          chk("rvalid_cycle", 32'(mcyc), 32'(e[48:33]));
          chk("rdata0", rdata0, e[49] ? 32'd0 : e[31:0]);
          chk("rdata1", rdata1, e[49] ? e[31:0] : 32'd0);
          chk("err", {30'd0, err}, e[49] ? {30'd0, e[32], 1'b0} : {31'd0, e[32]});
        end
      end else begin
        chk("quiet_rdata", rdata0 | rdata1, 32'd0);
        chk("quiet_err", {30'd0, err}, 32'd0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input int p, input logic w_i, input logic [1:0] s, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    int t;
    t = 0;
    we[p] = w_i; size[p] = s; sgn[p] = sg; addr[p] = a; wdata[p] = d;
    req[p] = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!gnt[p] && t < 100);
    if (!gnt[p]) begin
      n_vec++;
      n_err++;
      $display("FAIL grant_timeout: port %0d got gnt 0 expected 1 within 100 cycles", p);
    end
    @(posedge clk);
    #1;
    req[p] = 1'b0;
  endtask

  task automatic rand_port(input int p, input int n);
    logic [1:0]  s;
    logic [31:0] a;
    int          g;
    for (int i = 0; i < n; i++) begin
      s = ($urandom_range(0, 9) == 9) ? 2'd3 : 2'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = (s == 2'd1) ? (a & ~32'd1) : (s == 2'd2) ? (a & ~32'd3) : a;
      issue(p, 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom);
      g = $urandom_range(0, 4);
      if (g > 0) begin
        repeat (g) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req = 2'b00; we = 2'b00; sgn = 2'b00;
    for (int p = 0; p < 2; p++) begin
      size[p] = 2'd0; addr[p] = '0; wdata[p] = '0;
    end
    for (int i = 0; i < 1024; i++) begin
      dmem[i] = $urandom;
      for (int k = 0; k < 4; k++) ref_b[4*i + k] = dmem[i][8*k +: 8];
    end
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // Both ports request continuously from reset: grants must alternate 0,1,0,1.
    fork
      begin repeat (4) issue(0, 1'b0, 2'd2, 1'b0, 32'(4 * $urandom_range(0, 63)), 32'd0); end
      begin repeat (4) issue(1, 1'b0, 2'd2, 1'b0, 32'(4 * $urandom_range(0, 63)), 32'd0); end
    join

    // Word store/load, then the other port reads the freshly stored word.
    issue(0, 1'b1, 2'd2, 1'b0, 32'd500, 32'd250);
    issue(0, 1'b0, 2'd2, 1'b0, 32'd500, 32'd0);
    issue(1, 1'b0, 2'd2, 1'b0, 32'd500, 32'd0);

    // Byte and half lanes with sign/zero extension.
    issue(0, 1'b1, 2'd0, 1'b0, 32'd1001, 32'h0000_00A5);
    issue(0, 1'b0, 2'd0, 1'b1, 32'd1001, 32'd0);
    issue(0, 1'b0, 2'd0, 1'b0, 32'd1001, 32'd0);
    issue(0, 1'b1, 2'd1, 1'b0, 32'd1002, 32'h0000_8001);
    issue(0, 1'b0, 2'd1, 1'b1, 32'd1002, 32'd0);
    issue(1, 1'b0, 2'd1, 1'b0, 32'd1002, 32'd0);

    // Misaligned and illegal-size accesses, then a legal one.
    issue(0, 1'b0, 2'd2, 1'b0, 32'd1001, 32'd0);
    issue(1, 1'b1, 2'd1, 1'b0, 32'd1003, 32'h0000_1234);
    issue(0, 1'b1, 2'd3, 1'b0, 32'd1000, 32'hFFFF_FFFF);
    issue(0, 1'b0, 2'd2, 1'b0, 32'd1000, 32'd0);

    // Reset in the middle of ISSUE of a word store must suppress the write.
    issue(1, 1'b1, 2'd2, 1'b0, 32'd500, 32'h1111_2222);
    issue(0, 1'b1, 2'd2, 1'b0, 32'd500, 32'hDEAD_BEEF);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    issue(0, 1'b0, 2'd2, 1'b0, 32'd500, 32'd0);
    issue(1, 1'b0, 2'd0, 1'b1, 32'd503, 32'd0);

    // Randomized traffic from both ports.
    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join

    repeat (10) @(posedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
